// File: rtl/riscv_ifetch_pkg.sv
// Shared fetch-stage constants: default word width, NOP encoding and the buffered fetch-entry layout.
package riscv_constants;
  localparam int          WORD_LENGTH_DEF = 32;
  localparam logic [31:0] NOP             = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        misalign;
  } fetch_entry_t;
endpackage

// File: rtl/riscv_ifetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid channel plus the decode valid/ready channel.
interface riscv_ifetch_if #(parameter int WL = 32) ();
  logic          imem_req;
  logic [WL-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [WL-1:0] imem_rdata;
  logic          inst_valid;
  logic          inst_ready;
  logic [WL-1:0] inst;
  logic [WL-1:0] inst_pc;

  modport master (output imem_req, imem_addr, inst_valid, inst, inst_pc,
                  input  imem_gnt, imem_rvalid, imem_rdata, inst_ready);
  modport slave  (input  imem_req, imem_addr, inst_valid, inst, inst_pc,
                  output imem_gnt, imem_rvalid, imem_rdata, inst_ready);
endinterface

// File: rtl/riscv_ifetch_fifo.sv
// Synchronous FIFO with clear; a push into a full FIFO is accepted only alongside a pop.
module riscv_ifetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) mem[wp] <= din;
  end
endmodule

// File: rtl/riscv_ifetch.sv
// Instruction fetch: credit-limited issue to imem, in-order response capture, redirect discard.
// Optional RISCV_IFETCH_ALIGN_CHECK_EN: misaligned PCs become a NOP entry flagged inst_misalign.
module riscv_ifetch
  import riscv_constants::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] pc_in,
  output logic                   pc_advance,
  input  logic                   flush,
`ifdef RISCV_IFETCH_ALIGN_CHECK_EN
  output logic                   inst_misalign,
`endif
  riscv_ifetch_if.master         bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]          outstanding, discard, aq_count, ib_count;
  logic [CW:0]            in_use;
  logic                   credit, issue, rv_ok, after_reset;
  logic                   aq_full, aq_empty, ib_full, ib_empty, ib_push, ib_pop;
  logic [WORD_LENGTH-1:0] aq_pc;
  fetch_entry_t           ib_din, head;
  logic                   mis_push;

  assign in_use = {1'b0, outstanding} + {1'b0, ib_count};
  assign credit = (in_use < (CW+1)'(DEPTH));
  // Responses with nothing outstanding (e.g. stragglers from before reset) are ignored.
  assign rv_ok  = bus.imem_rvalid & ~aq_empty;

`ifdef RISCV_IFETCH_ALIGN_CHECK_EN
  logic halt, bad_pc;
  assign bad_pc       = (pc_in[1:0] != 2'b00);
  // Wait for all real fetches to land so the marker entry stays in program order.
  assign mis_push     = bad_pc & ~halt & ~reset & ~flush & credit & (outstanding == '0);
  assign bus.imem_req = ~reset & ~flush & credit & ~bad_pc & ~halt;
  assign inst_misalign = head.misalign;

  always_ff @(posedge clk) begin
    if (reset || flush) halt <= 1'b0;
    else if (mis_push)  halt <= 1'b1;
  end
`else
  assign mis_push     = 1'b0;
  assign bus.imem_req = ~reset & ~flush & credit;
`endif

  assign bus.imem_addr = pc_in;
  assign issue         = bus.imem_req & bus.imem_gnt;
  assign pc_advance    = issue;

  assign ib_push = (rv_ok & (discard == '0) & ~flush) | mis_push;
  assign ib_pop  = bus.inst_valid & bus.inst_ready & ~flush;
  assign ib_din  = mis_push ? fetch_entry_t'{pc: pc_in, inst: NOP, misalign: 1'b1}
                            : fetch_entry_t'{pc: aq_pc, inst: bus.imem_rdata, misalign: 1'b0};

  riscv_ifetch_fifo #(.WIDTH(WORD_LENGTH), .DEPTH(DEPTH)) u_addr_q (
    .clk(clk), .reset(reset), .clear(1'b0), .push(issue), .pop(rv_ok),
    .din(pc_in), .dout(aq_pc), .count(aq_count), .full(aq_full), .empty(aq_empty)
  );

  riscv_ifetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_buf (
    .clk(clk), .reset(reset), .clear(flush), .push(ib_push), .pop(ib_pop),
    .din(ib_din), .dout(head), .count(ib_count), .full(ib_full), .empty(ib_empty)
  );

  assign bus.inst_valid = ~ib_empty;
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      discard     <= '0;
      after_reset <= 1'b1;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(rv_ok);
      // Everything in flight at the redirect, minus a word landing this same edge, is stale.
      if (flush)                       discard <= outstanding - CW'(rv_ok);
      else if (rv_ok && discard != '0) discard <= discard - 1'b1;
      if (issue) after_reset <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.imem_rvalid && outstanding == '0 && !after_reset))
        else $error("riscv_ifetch: imem_rvalid with no fetch outstanding");
      assert (aq_count == outstanding) else $error("riscv_ifetch: address queue out of step");
      assert (!(issue && aq_full)) else $error("riscv_ifetch: issue past credit limit");
      assert (!(ib_push && ib_full && !ib_pop)) else $error("riscv_ifetch: buffer overflow");
`ifndef RISCV_IFETCH_ALIGN_CHECK_EN
      assert (!(bus.inst_valid && head.misalign)) else $error("riscv_ifetch: stray misalign flag");
`endif
    end
  end
endmodule

// File: tb/tb_riscv_ifetch.sv
// Scoreboard bench for riscv_ifetch: directed fetch scenarios, imem responder model, decode monitor.
module tb_riscv_ifetch;
  import riscv_constants::*;

  logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic        pc_advance;
`ifdef RISCV_IFETCH_ALIGN_CHECK_EN
  logic        inst_misalign;
`endif

  riscv_ifetch_if #(.WL(32)) bus ();

  riscv_ifetch dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_advance(pc_advance), .flush(flush),
`ifdef RISCV_IFETCH_ALIGN_CHECK_EN
    .inst_misalign(inst_misalign),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int           n_chk = 0, n_fail = 0, issue_cnt = 0;
  fetch_entry_t exp_q[$];
  logic [31:0]  resp_q[$];
  logic         hold = 1'b0, stray = 1'b0, redir = 1'b0, adv;
  logic [31:0]  redir_pc = 32'h0, ra;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // imem model + PC stage: capture issues at the edge, drive next-cycle response 1 after gnt.
  always @(posedge clk) begin
    adv = pc_advance;
    if (!reset && bus.imem_req && bus.imem_gnt) begin
      resp_q.push_back(bus.imem_addr);
      issue_cnt++;
    end
    #1;
    if (redir) begin pc_in = redir_pc; redir = 1'b0; end
    else if (adv) pc_in = pc_in + 32'd4;
    if (stray) begin
      bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; stray = 1'b0;
    end else if (!hold && resp_q.size() > 0) begin
      ra = resp_q.pop_front();
      bus.imem_rvalid = 1'b1; bus.imem_rdata = {16'hC0DE, ra[15:0]};
    end else begin
      bus.imem_rvalid = 1'b0;
    end
  end

  // Decode-side monitor: compare every accepted instruction against the scoreboard.
  always @(negedge clk) begin
    fetch_entry_t e;
    #3;
    if (!reset && !flush && bus.inst_valid && bus.inst_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_inst: got pc %h inst %h, expected none", bus.inst_pc, bus.inst);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", bus.inst_pc, e.pc);
        check("inst", bus.inst, e.inst);
`ifdef RISCV_IFETCH_ALIGN_CHECK_EN
        check("inst_misalign", {31'b0, inst_misalign}, {31'b0, e.misalign});
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_inst(input logic [31:0] pc, input logic [31:0] inst, input logic mis);
    exp_q.push_back(fetch_entry_t'{pc: pc, inst: inst, misalign: mis});
  endtask

  task automatic issue_n(input int n);
    int target = issue_cnt + n;
    bus.imem_gnt = 1'b1;
    for (int i = 0; i < 200 && issue_cnt < target; i++) @(negedge clk);
    bus.imem_gnt = 1'b0;
    check("issue_count", issue_cnt, target);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic redirect(input logic [31:0] pc);
    flush = 1'b1; redir = 1'b1; redir_pc = pc;
    tick(1);
    flush = 1'b0;
  endtask

  initial begin
    int c0;
    bus.imem_gnt = 1'b0; bus.inst_ready = 1'b1;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    tick(2); #1;
    check("rst_req", bus.imem_req, 0);
    check("rst_inst_valid", bus.inst_valid, 0);
    check("rst_pc_advance", pc_advance, 0);
    tick(1); reset = 1'b0;

    // 1: back-to-back fetches 0,4,8
    expect_inst(32'h0, 32'hC0DE_0000, 1'b0);
    expect_inst(32'h4, 32'hC0DE_0004, 1'b0);
    expect_inst(32'h8, 32'hC0DE_0008, 1'b0);
    issue_n(3);
    drain();

    // 2: decode stall fills credits, then releases
    bus.inst_ready = 1'b0; bus.imem_gnt = 1'b1; c0 = issue_cnt;
    tick(6); #1;
    check("stall_req", bus.imem_req, 0);
    check("stall_pc_advance", pc_advance, 0);
    check("stall_issues", issue_cnt - c0, 2);
    check("stall_valid", bus.inst_valid, 1);
    check("stall_head_pc", bus.inst_pc, 32'hC);
    bus.imem_gnt = 1'b0;
    expect_inst(32'hC, 32'hC0DE_000C, 1'b0);
    expect_inst(32'h10, 32'hC0DE_0010, 1'b0);
    bus.inst_ready = 1'b1;
    drain();
    expect_inst(32'h14, 32'hC0DE_0014, 1'b0);
    issue_n(1);
    drain();

    // 3: grant withheld, address held stable
    redirect(32'h100);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wait_addr", bus.imem_addr, 32'h100);
      check("wait_req", bus.imem_req, 1);
      check("wait_pc_advance", pc_advance, 0);
      tick(1);
    end
    expect_inst(32'h100, 32'hC0DE_0100, 1'b0);
    bus.imem_gnt = 1'b1; #1;
    check("gnt_pc_advance", pc_advance, 1);
    tick(1);
    bus.imem_gnt = 1'b0; #1;
    check("post_gnt_pc_advance", pc_advance, 0);
    drain();

    // 4: flush with two in flight
    hold = 1'b1;
    issue_n(2);
    #1 check("inflight_valid", bus.inst_valid, 0);
    redirect(32'h200);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("flushed_valid", bus.inst_valid, 0);
      tick(1);
    end
    expect_inst(32'h200, 32'hC0DE_0200, 1'b0);
    issue_n(1);
    drain();

    // 5: reset with two buffered, then a stray response
    bus.inst_ready = 1'b0;
    issue_n(2);
    tick(3); #1;
    check("prereset_valid", bus.inst_valid, 1);
    reset = 1'b1;
    tick(1); #1;
    check("reset_valid", bus.inst_valid, 0);
    check("reset_req", bus.imem_req, 0);
    reset = 1'b0; stray = 1'b1;
    tick(1);
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("stray_valid", bus.inst_valid, 0);
      tick(1);
    end
    expect_inst(32'h20C, 32'hC0DE_020C, 1'b0);
    issue_n(1);
    drain();

`ifdef RISCV_IFETCH_ALIGN_CHECK_EN
    // 6: misaligned PC becomes a flagged NOP and halts issue
    redirect(32'h102);
    expect_inst(32'h102, NOP, 1'b1);
    bus.imem_gnt = 1'b1; c0 = issue_cnt;
    tick(4); #1;
    check("mis_req", bus.imem_req, 0);
    check("mis_pc_advance", pc_advance, 0);
    check("mis_issues", issue_cnt - c0, 0);
    drain();
    bus.imem_gnt = 1'b0;
    redirect(32'h300);
    expect_inst(32'h300, 32'hC0DE_0300, 1'b0);
    issue_n(1);
    drain();
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
